nes_pad_scheduler: RTL and testbench
====================================

# nes_pad_scheduler

Owns the physical NES controller bus for both player ports: shared latch, shared clock, and two serial data lines. It periodically scans both pads and double-buffers the decoded button bytes. It also serves CPU-side $4016 strobe writes and $4016/$4017 serial reads with NES-accurate shift semantics. It sits between the pad pins and the CPU/APU register decode, and replaces ad-hoc free-running gamepad readers.

## Interface
- CLK_FREQ, 27_000_000: system clock frequency in Hz.
- POLL_HZ, 120: scan rate; POLL_CYCLES = CLK_FREQ/POLL_HZ (225000 at default).
- HALF_CYCLES, 1620: pad-bus half period in clocks (60 us at 27 MHz); must be ≥2.
- Constraint: POLL_CYCLES > 18*HALF_CYCLES + 2 (elaboration-time check).

- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  scanning enable; sampled only in IDLE.
- o_pad_latch  out  1  shared latch to both pads.
- o_pad_clk  out  1  shared clock to both pads.
- i_pad_data  in  2  serial data, [0]=port 1, [1]=port 2, active-low.
- o_buttons_p1 / o_buttons_p2  out  8 each  committed states, 1=pressed; bit0..7 = A,B,Select,Start,Up,Down,Left,Right.
- o_frame_valid  out  1  one-cycle pulse when new states commit.
- i_cpu_wr  in  1  write to $4016.
- i_cpu_wdata  in  1  bit0 of the $4016 write (strobe).
- i_cpu_rd  in  2  one-hot read: [0]=$4016, [1]=$4017.
- o_cpu_rdata  out  2  bit0 of the port shift register, one per port, registered.

## Operation
- Poll timer: free-running 0..POLL_CYCLES-1; tick when it wraps to 0. Tick in IDLE with i_enable=1 starts a scan. A tick while busy is dropped, never queued.
- FSM: IDLE → LATCH → (LOW → HIGH)×8 → COMMIT → IDLE.
- LATCH: o_pad_latch=1 for 2*HALF_CYCLES.
- LOW: HALF_CYCLES with the clock low. On its last cycle, sample ~i_pad_data into bit n of both capture registers, where n = bit index 0..7.
- HIGH: o_pad_clk=1 for HALF_CYCLES, then bit index increments. After bit 7 HIGH, go to COMMIT.
- COMMIT: one cycle; capture registers → o_buttons_p1/p2; o_frame_valid=1.
- Deasserting i_enable mid-scan does not abort; the scan completes and commits.
- CPU side, per port:
  - Strobe register S is set by i_cpu_wr with i_cpu_wdata.
  - While S=1, the shift register reloads every cycle from the committed buttons.
  - While S=0, each read strobe shifts it right, filling 1 at bit7.
  - o_cpu_rdata[p] is updated on a read with the pre-shift bit0.
  - After 8 reads a port returns 1 indefinitely.
- Write and read in the same cycle: the read returns bit0 as it was before this cycle; the shift register then takes the write's effect. If new S=1, it reloads and no shift occurs.
- COMMIT and reload in the same cycle: the reload uses the newly committed value.

## Timing
- Reset values: all outputs 0; FSM IDLE; poll counter 0; S=0; shift registers 0x00; capture registers 0x00.
- Async reset mid-scan drops latch and clock the same instant. The first scan after release waits for the next tick, POLL_CYCLES after release.
- Scan length: 18*HALF_CYCLES + 1 cycles from the first latch-high cycle to the o_frame_valid pulse.
- o_pad_latch and o_pad_clk come directly from flops, with no combinational glitches. They are never high simultaneously.
- o_cpu_rdata has 1-cycle latency from i_cpu_rd and holds between reads.

## Structure
- Package nes_pad_pkg: FSM state enum; button bit index constants BTN_A..BTN_RIGHT; BUTTON_W=8.
- One natural sub-module, nes_pad_shift_port, instantiated twice. It holds one port's strobe-following shift register and read logic.
- The scan FSM, poll timer and phase counter stay in the top level.

## Test plan
- HALF=4, POLL=100, pad1 drives A+Start (data low in LOW phases 0 and 3), pad2 idle high → after 73 cycles of scan, o_frame_valid pulses; p1=0x09, p2=0x00.
- Waveform check, same setup: latch high exactly 8 cycles; 8 clock pulses each 4 high / 4 low; latch and clock never overlap.
- CPU: write 1, write 0, then 10 reads of $4016 with p1=0x09 → rdata[0] = 1,0,0,1,0,0,0,0,1,1.
- Write 1 and read $4016 in the same cycle after 3 prior shifts → returns the pre-shift bit; the next read with S=1 returns A.
- Assert reset mid-HIGH phase of bit 4 → latch and clock are 0 immediately; buttons stay 0x00; the next scan starts 100 cycles after release.
- i_enable=0 at the tick → no latch activity. Drop i_enable during bit 2 of an active scan → the scan completes and commits.

Source files
------------

// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the NES controller bus scheduler.
package nes_pad_pkg;

  localparam int BUTTON_W = 8;

  // Button bit positions in the decoded bytes (1 = pressed).
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Scan FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_LOW    = 3'd2,
    ST_HIGH   = 3'd3,
    ST_COMMIT = 3'd4
  } pad_state_t;

endpackage

// File: rtl/nes_pad_shift_port.sv
// One CPU-visible controller port: strobe register, button shift register
// and registered read data with NES $4016/$4017 shift behaviour.
module nes_pad_shift_port
  import nes_pad_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wr,
  input  logic                i_wdata,
  input  logic                i_rd,
  input  logic [BUTTON_W-1:0] i_buttons,
  output logic                o_rdata
);

  logic                strobe_q;
  logic [BUTTON_W-1:0] shift_q;
  logic                rdata_q;
  logic                strobe_eff;

  // A write in this cycle decides the shift register's behaviour at this
  // edge; otherwise the stored strobe does.
  assign strobe_eff = i_wr ? i_wdata : strobe_q;

  // Strobe, shift register and read data; a read always returns the bit0
  // held before this edge, whatever the write does to the register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      strobe_q <= 1'b0;
      shift_q  <= '0;
      rdata_q  <= 1'b0;
    end else begin
      if (i_wr) begin
        strobe_q <= i_wdata;
      end
      if (strobe_eff) begin
        shift_q <= i_buttons;
      end else if (i_rd) begin
        shift_q <= {1'b1, shift_q[BUTTON_W-1:1]};
      end
      if (i_rd) begin
        rdata_q <= shift_q[0];
      end
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/nes_pad_scheduler.sv
// Owns the NES pad bus for both ports: periodic latch/clock scan of the two
// pads, double-buffered button bytes, and the CPU-side strobe/serial reads.
//
// Output timing: o_frame_valid is a one-cycle pulse in the same cycle that
// o_buttons_p1/p2 first show the new bytes; there is no back-pressure. A CPU
// read (i_cpu_rd bit set for one cycle) produces its bit on o_cpu_rdata in
// the following cycle, and that value holds until the next read of the port.
module nes_pad_scheduler
  import nes_pad_pkg::*;
#(
  parameter int CLK_FREQ    = 27_000_000,
  parameter int POLL_HZ     = 120,
  parameter int HALF_CYCLES = 1620
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  output logic                o_pad_latch,
  output logic                o_pad_clk,
  input  logic [1:0]          i_pad_data,
  output logic [BUTTON_W-1:0] o_buttons_p1,
  output logic [BUTTON_W-1:0] o_buttons_p2,
  output logic                o_frame_valid,
  input  logic                i_cpu_wr,
  input  logic                i_cpu_wdata,
  input  logic [1:0]          i_cpu_rd,
  output logic [1:0]          o_cpu_rdata,
  output pad_state_t          o_dbg_state
);

  localparam int POLL_CYCLES = CLK_FREQ / POLL_HZ;
  localparam int POLL_W      = $clog2(POLL_CYCLES);
  localparam int PHASE_W     = $clog2(2 * HALF_CYCLES);

  localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
  localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(2 * HALF_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_CYCLES - 1);

  if (HALF_CYCLES < 2) begin : g_bad_half
    $error("HALF_CYCLES must be at least 2");
  end
  if (POLL_CYCLES <= 18 * HALF_CYCLES + 2) begin : g_bad_poll
    $error("poll period too short for a full scan");
  end

  pad_state_t          state_q, state_d;
  logic [POLL_W-1:0]   poll_q;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [2:0]          bit_q, bit_d;
  logic [BUTTON_W-1:0] cap_p1_q, cap_p1_d;
  logic [BUTTON_W-1:0] cap_p2_q, cap_p2_d;
  logic [BUTTON_W-1:0] buttons_p1_q, buttons_p2_q;
  logic                latch_q, pad_clk_q, frame_valid_q;
  logic                tick;
  logic                commit_now;
  logic [BUTTON_W-1:0] src_p1, src_p2;

  assign tick = (poll_q == POLL_LAST);

  // Free-running poll timer; tick marks the wrap back to zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      poll_q <= '0;
    end else if (tick) begin
      poll_q <= '0;
    end else begin
      poll_q <= poll_q + 1'b1;
    end
  end

  // Scan FSM next state, phase/bit counters and capture of the pad bits.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q + 1'b1;
    bit_d    = bit_q;
    cap_p1_d = cap_p1_q;
    cap_p2_d = cap_p2_q;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (tick && i_enable) begin
          state_d = ST_LATCH;
          bit_d   = '0;
        end
      end
      ST_LATCH: begin
        if (phase_q == LATCH_LAST) begin
          state_d = ST_LOW;
          phase_d = '0;
        end
      end
      ST_LOW: begin
        if (phase_q == HALF_LAST) begin
          cap_p1_d[bit_q] = ~i_pad_data[0];
          cap_p2_d[bit_q] = ~i_pad_data[1];
          state_d         = ST_HIGH;
          phase_d         = '0;
        end
      end
      ST_HIGH: begin
        if (phase_q == HALF_LAST) begin
          phase_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_COMMIT;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = ST_LOW;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  assign commit_now = (state_d == ST_COMMIT);

  // State, counters, capture registers and the glitch-free pad/frame flops,
  // all decoded from the next state so they line up with state_q.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      bit_q         <= '0;
      cap_p1_q      <= '0;
      cap_p2_q      <= '0;
      buttons_p1_q  <= '0;
      buttons_p2_q  <= '0;
      latch_q       <= 1'b0;
      pad_clk_q     <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      bit_q         <= bit_d;
      cap_p1_q      <= cap_p1_d;
      cap_p2_q      <= cap_p2_d;
      latch_q       <= (state_d == ST_LATCH);
      pad_clk_q     <= (state_d == ST_HIGH);
      frame_valid_q <= commit_now;
      if (commit_now) begin
        buttons_p1_q <= cap_p1_q;
        buttons_p2_q <= cap_p2_q;
      end
    end
  end

  // Ports reloading on the commit edge must see the freshly captured bytes.
  assign src_p1 = commit_now ? cap_p1_q : buttons_p1_q;
  assign src_p2 = commit_now ? cap_p2_q : buttons_p2_q;

  nes_pad_shift_port u_port1 (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr      (i_cpu_wr),
    .i_wdata   (i_cpu_wdata),
    .i_rd      (i_cpu_rd[0]),
    .i_buttons (src_p1),
    .o_rdata   (o_cpu_rdata[0])
  );

  nes_pad_shift_port u_port2 (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr      (i_cpu_wr),
    .i_wdata   (i_cpu_wdata),
    .i_rd      (i_cpu_rd[1]),
    .i_buttons (src_p2),
    .o_rdata   (o_cpu_rdata[1])
  );

  assign o_pad_latch   = latch_q;
  assign o_pad_clk     = pad_clk_q;
  assign o_frame_valid = frame_valid_q;
  assign o_buttons_p1  = buttons_p1_q;
  assign o_buttons_p2  = buttons_p2_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_nes_pad_scheduler.sv
// Bench for nes_pad_scheduler: pad model on the bus, directed scans and CPU
// register sequences, scoreboard queues checked by negedge monitors.
module tb_nes_pad_scheduler;
  import nes_pad_pkg::*;

  localparam int HALF = 4;
  localparam int POLL = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       enable = 1'b0;
  logic [1:0] pad_data;
  logic       cpu_wr = 1'b0;
  logic       cpu_wdata = 1'b0;
  logic [1:0] cpu_rd = 2'b00;
  logic       pad_latch, pad_clk, frame_valid;
  logic [7:0] buttons_p1, buttons_p2;
  logic [1:0] cpu_rdata;
  pad_state_t dbg_state;

  nes_pad_scheduler #(
    .CLK_FREQ    (12000),
    .POLL_HZ     (120),
    .HALF_CYCLES (HALF)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (enable),
    .o_pad_latch   (pad_latch),
    .o_pad_clk     (pad_clk),
    .i_pad_data    (pad_data),
    .o_buttons_p1  (buttons_p1),
    .o_buttons_p2  (buttons_p2),
    .o_frame_valid (frame_valid),
    .i_cpu_wr      (cpu_wr),
    .i_cpu_wdata   (cpu_wdata),
    .i_cpu_rd      (cpu_rd),
    .o_cpu_rdata   (cpu_rdata),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- pad model (active-low serial, 4021-style) ----------------
  logic [7:0] pad1_btn = 8'h00;
  logic [7:0] pad2_btn = 8'h00;
  logic [3:0] pad_idx = 4'd0;
  logic       clk_prev = 1'b0;

  always @(negedge clk) begin
    if (pad_latch) pad_idx <= 4'd0;
    else if (pad_clk && !clk_prev && !pad_idx[3]) pad_idx <= pad_idx + 4'd1;
    clk_prev <= pad_clk;
  end

  assign pad_data[0] = pad_idx[3] ? 1'b0 : ~pad1_btn[pad_idx[2:0]];
  assign pad_data[1] = pad_idx[3] ? 1'b0 : ~pad2_btn[pad_idx[2:0]];

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [15:0] frame_q[$];   // {p2, p1}
  logic [3:0]  rd_q[$];      // {mask[1:0], value[1:0]}

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_op(input logic wr, input logic wd, input logic [1:0] rd, input logic [1:0] val);
    cpu_wr = wr;
    cpu_wdata = wd;
    cpu_rd = rd;
    if (rd != 2'b00) rd_q.push_back({rd, val});
    step();
    cpu_wr = 1'b0;
    cpu_wdata = 1'b0;
    cpu_rd = 2'b00;
  endtask

  task automatic wait_latch(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!pad_latch && n < 400);
    if (!pad_latch) fail_now("wait_latch_timeout");
  endtask

  task automatic wait_frame_now();
    int n;
    n = 0;
    while (!frame_valid && n < 400) begin
      step();
      n++;
    end
    if (!frame_valid) fail_now("wait_frame_timeout");
  endtask

  task automatic wait_frame();
    wait_frame_now();
    step();
  endtask

  // ---------------- monitors ----------------
  logic rd_seen;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_seen <= 1'b0;
    else rd_seen <= |cpu_rd;
  end

  initial begin : rd_monitor
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && rd_seen) begin
        if (rd_q.size() == 0) begin
          fail_now("cpu_rdata_unexpected");
        end else begin
          e = rd_q.pop_front();
          check("cpu_rdata", {14'd0, cpu_rdata & e[3:2]}, {14'd0, e[1:0] & e[3:2]});
        end
      end
    end
  end

  int cyc = 0;
  initial begin : bus_monitor
    int latch_run, hi_run, lo_run, pulses, latch_start;
    logic in_scan;
    logic [15:0] e;
    latch_run = 0; hi_run = 0; lo_run = 0; pulses = 0; latch_start = 0; in_scan = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        latch_run = 0; hi_run = 0; lo_run = 0; pulses = 0; in_scan = 1'b0;
      end else begin
        if (pad_latch || pad_clk)
          check("latch_clk_overlap", {15'd0, pad_latch & pad_clk}, 16'd0);
        if (pad_latch) begin
          if (latch_run == 0) latch_start = cyc;
          latch_run++;
          pulses = 0;
        end else if (latch_run > 0) begin
          check("latch_len", 16'(latch_run), 16'(2 * HALF));
          latch_run = 0;
          in_scan = 1'b1;
          lo_run = 0;
        end
        if (pad_clk) begin
          if (hi_run == 0 && in_scan) check("clk_low_len", 16'(lo_run), 16'(HALF));
          hi_run++;
        end else begin
          if (hi_run > 0) begin
            check("clk_high_len", 16'(hi_run), 16'(HALF));
            hi_run = 0;
            pulses++;
            lo_run = 0;
            if (pulses == 8) in_scan = 1'b0;
          end
          if (in_scan && !pad_latch) lo_run++;
        end
        if (frame_valid) begin
          check("clk_pulses", 16'(pulses), 16'd8);
          check("scan_len", 16'(cyc - latch_start + 1), 16'(18 * HALF + 1));
          if (frame_q.size() == 0) begin
            fail_now("frame_unexpected");
          end else begin
            e = frame_q.pop_front();
            check("frame_buttons", {buttons_p2, buttons_p1}, e);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [9:0] seq_p1;
  initial begin : stimulus
    int n;
    int lc;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_latch", {15'd0, pad_latch}, 16'd0);
    check("rst_clk", {15'd0, pad_clk}, 16'd0);
    check("rst_frame_valid", {15'd0, frame_valid}, 16'd0);
    check("rst_buttons", {buttons_p2, buttons_p1}, 16'h0000);
    check("rst_rdata", {14'd0, cpu_rdata}, 16'd0);
    check("rst_state", 16'(dbg_state), 16'(ST_IDLE));
    rst_n = 1'b1;

    // scan 1: pad1 A+Start, pad2 idle; first latch one poll period after release
    pad1_btn = 8'h09;
    pad2_btn = 8'h00;
    frame_q.push_back(16'h0009);
    enable = 1'b1;
    wait_latch(n);
    check("first_latch_delay", 16'(n), 16'(POLL));
    enable = 1'b0;
    wait_frame();

    // CPU: strobe then 10 serial reads of $4016
    cpu_op(1'b1, 1'b1, 2'b00, 2'b00);
    cpu_op(1'b1, 1'b0, 2'b00, 2'b00);
    seq_p1 = 10'b11_0000_1001;   // read order is bit0 first
    for (int i = 0; i < 10; i++) cpu_op(1'b0, 1'b0, 2'b01, {1'b0, seq_p1[i]});
    repeat (3) step();
    check("rdata_hold", {15'd0, cpu_rdata[0]}, 16'd1);

    // write 1 and read in the same cycle after 3 shifts (bit0 = Start = 1)
    cpu_op(1'b1, 1'b1, 2'b00, 2'b00);
    cpu_op(1'b1, 1'b0, 2'b00, 2'b00);
    cpu_op(1'b0, 1'b0, 2'b01, 2'b01);
    cpu_op(1'b0, 1'b0, 2'b01, 2'b00);
    cpu_op(1'b0, 1'b0, 2'b01, 2'b00);
    cpu_op(1'b1, 1'b1, 2'b01, 2'b01);
    cpu_op(1'b0, 1'b0, 2'b01, 2'b01);
    // same, after 1 shift (pre-shift bit0 = B = 0), then A while strobed
    cpu_op(1'b1, 1'b0, 2'b00, 2'b00);
    cpu_op(1'b0, 1'b0, 2'b01, 2'b01);
    cpu_op(1'b1, 1'b1, 2'b01, 2'b00);
    cpu_op(1'b0, 1'b0, 2'b01, 2'b01);
    cpu_op(1'b1, 1'b0, 2'b00, 2'b00);

    // enable low across ticks: no bus activity
    enable = 1'b0;
    lc = 0;
    repeat (250) begin
      step();
      if (pad_latch || pad_clk) lc++;
    end
    check("disabled_no_activity", 16'(lc), 16'd0);

    // scan 2: drop enable during bit 2, scan still commits
    pad1_btn = 8'h60;
    pad2_btn = 8'hA5;
    frame_q.push_back(16'hA560);
    enable = 1'b1;
    wait_latch(n);
    repeat (26) step();
    check("bit2_state", 16'(dbg_state), 16'(ST_LOW));
    enable = 1'b0;
    wait_frame();

    // read both ports 9 times: p1=0x60, p2=0xA5, then fill ones
    cpu_op(1'b1, 1'b1, 2'b00, 2'b00);
    cpu_op(1'b1, 1'b0, 2'b00, 2'b00);
    cpu_op(1'b0, 1'b0, 2'b11, 2'b10);
    cpu_op(1'b0, 1'b0, 2'b11, 2'b00);
    cpu_op(1'b0, 1'b0, 2'b11, 2'b10);
    cpu_op(1'b0, 1'b0, 2'b11, 2'b00);
    cpu_op(1'b0, 1'b0, 2'b11, 2'b00);
    cpu_op(1'b0, 1'b0, 2'b11, 2'b11);
    cpu_op(1'b0, 1'b0, 2'b11, 2'b01);
    cpu_op(1'b0, 1'b0, 2'b11, 2'b10);
    cpu_op(1'b0, 1'b0, 2'b11, 2'b11);

    // scan 3 with strobe held: read in the commit cycle sees the new bytes
    cpu_op(1'b1, 1'b1, 2'b00, 2'b00);
    pad1_btn = 8'h01;
    pad2_btn = 8'h80;
    frame_q.push_back(16'h8001);
    enable = 1'b1;
    wait_latch(n);
    enable = 1'b0;
    wait_frame_now();
    cpu_op(1'b0, 1'b0, 2'b11, 2'b01);
    cpu_op(1'b1, 1'b0, 2'b00, 2'b00);

    // scan 4: reset in the HIGH phase of bit 4
    pad1_btn = 8'hFF;
    pad2_btn = 8'hFF;
    enable = 1'b1;
    wait_latch(n);
    repeat (45) step();
    check("bit4_high_clk", {15'd0, pad_clk}, 16'd1);
    check("bit4_high_state", 16'(dbg_state), 16'(ST_HIGH));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_latch", {15'd0, pad_latch}, 16'd0);
    check("async_rst_clk", {15'd0, pad_clk}, 16'd0);
    check("async_rst_buttons", {buttons_p2, buttons_p1}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    frame_q.push_back(16'hFFFF);
    rst_n = 1'b1;
    wait_latch(n);
    check("latch_after_release", 16'(n), 16'(POLL));
    check("buttons_kept_zero", {buttons_p2, buttons_p1}, 16'h0000);
    enable = 1'b0;
    wait_frame();
    repeat (3) step();

    check("frame_q_drained", 16'(frame_q.size()), 16'd0);
    check("rd_q_drained", 16'(rd_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
